// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Central pipeline controller for the 5-stage core. It produces the
// stall/flush pair for each pipeline register (IF/ID, ID/EX, EX/MEM and
// MEM/WB). It also resolves load-use interlocks, data-bus busy stalls, taken
// branches, exception entry (flush, drain, vector) and exception return, and
// it drives the PC redirect.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, two performance counters are added as outputs:
//   - perf_stall_cnt_o counts the cycles in which if_stall_o is high.
//   - perf_flush_cnt_o counts branch redirects, erets and exception entries.
//   When undefined, the counters and their ports are absent.
//
// Ports
//   clk, reset            clock; asynchronous, active-high reset
//   if_busy_i             instruction fetch bus not ready
//   mem_busy_i            data bus access in progress
//   id_ra_addr_i/_use_i   ID source A register and its read enable
//   id_rb_addr_i/_use_i   ID source B register and its read enable
//   ex_en_i               EX holds a valid instruction
//   ex_load_i             EX instruction is a load
//   ex_dst_addr_i         EX destination register
//   ex_gpr_we_n_i         EX writes GPR (active-low)
//   br_taken_i            ID resolved a taken branch/jump
//   br_target_i           branch target word address
//   exp_req_i             MEM stage raises an exception
//   exp_code_i            exception cause
//   exp_pc_i              PC of the faulting instruction
//   eret_i                ID decodes an exception return
//   *_stall_o             hold the named pipeline register
//   *_flush_o             load a bubble into the named pipeline register
//   pc_load_o / new_pc_o  PC redirect strobe and address
//   epc_o / exp_cause_o   saved exception PC and cause
//   trap_busy_o           controller is trapping (not in RUN)
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [29:0] EXP_VECTOR   = 30'h0000_0040,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy_i,
    input  logic        mem_busy_i,
    input  logic [4:0]  id_ra_addr_i,
    input  logic [4:0]  id_rb_addr_i,
    input  logic        id_ra_use_i,
    input  logic        id_rb_use_i,
    input  logic        ex_en_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_dst_addr_i,
    input  logic        ex_gpr_we_n_i,
    input  logic        br_taken_i,
    input  logic [29:0] br_target_i,
    input  logic        exp_req_i,
    input  logic [2:0]  exp_code_i,
    input  logic [29:0] exp_pc_i,
    input  logic        eret_i,
    output logic        if_stall_o,
    output logic        id_stall_o,
    output logic        ex_stall_o,
    output logic        mem_stall_o,
    output logic        if_flush_o,
    output logic        id_flush_o,
    output logic        ex_flush_o,
    output logic        mem_flush_o,
    output logic        pc_load_o,
    output logic [29:0] new_pc_o,
    output logic [29:0] epc_o,
    output logic [2:0]  exp_cause_o,
    output logic        trap_busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_VECTOR
    } state_e;

    // The drain counter holds the number of DRAIN cycles still to go after
    // the current one, so it is loaded with DRAIN_CYCLES-1 on entry.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] epc_q, epc_d;
    logic [2:0]  cause_q, cause_d;

    logic ra_hit;
    logic rb_hit;
    logic load_use;

    logic in_run;
    logic sel_busy;
    logic sel_exp;
    logic sel_eret;
    logic sel_haz;
    logic sel_br;
    logic sel_ifb;

    // Load-use interlock: a load in EX whose destination is read by the
    // instruction in ID. Register 0 is hard-wired, so it never interlocks.
    always_comb begin
        ra_hit   = id_ra_use_i && (id_ra_addr_i == ex_dst_addr_i);
        rb_hit   = id_rb_use_i && (id_rb_addr_i == ex_dst_addr_i);
        load_use = ex_en_i && ex_load_i && !ex_gpr_we_n_i &&
                   (ex_dst_addr_i != 5'd0) && (ra_hit || rb_hit);
    end

    // RUN-state priority decode. Exactly one select is high at most, so the
    // output and next-state logic never have to resolve overlapping sources.
    // A hazard masks br_taken until the load result is available.
    always_comb begin
        in_run   = (state_q == ST_RUN);
        sel_busy = in_run && mem_busy_i;
        sel_exp  = in_run && !mem_busy_i && exp_req_i;
        sel_eret = in_run && !mem_busy_i && !exp_req_i && eret_i;
        sel_haz  = in_run && !mem_busy_i && !exp_req_i && !eret_i && load_use;
        sel_br   = in_run && !mem_busy_i && !exp_req_i && !eret_i &&
                   !load_use && br_taken_i;
        sel_ifb  = in_run && !mem_busy_i && !exp_req_i && !eret_i &&
                   !load_use && !br_taken_i && if_busy_i;
    end

    // State register together with the saved trap context. Because the
    // reset is asynchronous, the trap is abandoned at once and epc clears
    // in the same cycle that reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            epc_q   <= 30'd0;
            cause_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic. An exception entry latches its context and loads the
    // drain counter. DRAIN counts down and vectors after the last drain
    // cycle. A busy data bus freezes the drain so that the in-flight access
    // can finish before the vector fetch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_RUN: begin
                if (sel_exp) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                    epc_d   = exp_pc_i;
                    cause_d = exp_code_i;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy_i) begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_VECTOR;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_VECTOR: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output logic. A source that is not selected leaves its outputs at 0,
    // so a stall and a flush can never be driven onto the same register.
    always_comb begin
        if_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        ex_stall_o  = 1'b0;
        mem_stall_o = 1'b0;
        if_flush_o  = 1'b0;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        mem_flush_o = 1'b0;
        pc_load_o   = 1'b0;
        new_pc_o    = 30'd0;
        trap_busy_o = (state_q != ST_RUN);
        unique case (state_q)
            ST_RUN: begin
                if (sel_busy) begin
                    if_stall_o  = 1'b1;
                    id_stall_o  = 1'b1;
                    ex_stall_o  = 1'b1;
                    mem_stall_o = 1'b1;
                end else if (sel_exp) begin
                    if_flush_o  = 1'b1;
                    id_flush_o  = 1'b1;
                    ex_flush_o  = 1'b1;
                    mem_flush_o = 1'b1;
                end else if (sel_eret) begin
                    pc_load_o  = 1'b1;
                    new_pc_o   = epc_q;
                    if_flush_o = 1'b1;
                end else if (sel_haz) begin
                    if_stall_o = 1'b1;
                    id_flush_o = 1'b1;
                end else if (sel_br) begin
                    pc_load_o  = 1'b1;
                    new_pc_o   = br_target_i;
                    if_flush_o = 1'b1;
                end else if (sel_ifb) begin
                    if_flush_o = 1'b1;
                end
            end
            ST_DRAIN: begin
                if_flush_o  = 1'b1;
                id_flush_o  = 1'b1;
                ex_flush_o  = 1'b1;
                mem_flush_o = 1'b1;
            end
            ST_VECTOR: begin
                pc_load_o  = 1'b1;
                new_pc_o   = EXP_VECTOR;
                if_flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign epc_o       = epc_q;
    assign exp_cause_o = cause_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Performance counters. Both wrap naturally at 2^32. A flush event is
    // counted once per redirecting source. The DRAIN/VECTOR cycles of an
    // exception are part of the single entry event and are not counted again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (if_stall_o) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (sel_exp || sel_eret || sel_br) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
